song_select_ctrl: RTL and testbench

//   User-facing menu controller that feeds the seven-segment display stage.
//   It debounces four push-buttons and runs an IDLE/BROWSE/PLAY menu FSM.
//   It drives the display's song number (num) and display mode (mode), and

---
 rtl/song_select_ctrl_pkg.sv | 32 +++
 rtl/song_select_ctrl_if.sv | 29 ++
 rtl/song_select_ctrl_btn_debounce.sv | 44 ++++
 rtl/song_select_ctrl.sv | 75 +++++++
 tb/tb_song_select_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/song_select_ctrl_pkg.sv
// Shared constants for the song menu: display mode codes, FSM state codes
// and selection wrap helpers. The display stage decodes the same mode values.
package song_select_ctrl_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_BROWSE = 3'b010;
  localparam logic [2:0] MODE_PLAY   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  function automatic logic [2:0] mode_of(state_t s);
    case (s)
      ST_BROWSE: return MODE_BROWSE;
      ST_PLAY:   return MODE_PLAY;
      default:   return MODE_IDLE;
    endcase
  endfunction

  // Song numbers are 1-based, so both directions wrap between 1 and n.
  function automatic logic [3:0] wrap_next(logic [3:0] cur, logic [3:0] n);
    return (cur == n) ? 4'd1 : cur + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_prev(logic [3:0] cur, logic [3:0] n);
    return (cur == 4'd1) ? n : cur - 4'd1;
  endfunction

endpackage

// File: rtl/song_select_ctrl_if.sv
// Button inputs and display/player outputs of the song menu controller.
interface song_select_ctrl_if;
  import song_select_ctrl_pkg::*;

  // No valid/ready pairs here: buttons are raw levels, song_done and
  // song_start are single-cycle pulses, num/mode/play_active are held levels.
  logic       btn_up;
  logic       btn_down;
  logic       btn_confirm;
  logic       btn_back;
  logic       song_done;
  logic [3:0] num;
  logic [2:0] mode;
  logic       song_start;
  logic       play_active;
  state_t     state;
  logic [3:0] btn_level;

  modport master (
    output btn_up, btn_down, btn_confirm, btn_back, song_done,
    input  num, mode, song_start, play_active, state, btn_level
  );

  modport slave (
    input  btn_up, btn_down, btn_confirm, btn_back, song_done,
    output num, mode, song_start, play_active, state, btn_level
  );

endinterface

// File: rtl/song_select_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, accepted level and
// a single-cycle pulse on each accepted press (releases are silent).
module btn_debounce #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/song_select_ctrl.sv
// Menu controller: debounces four buttons and runs the IDLE/BROWSE/PLAY FSM
// that drives the display's song number/mode and the player start pulse.
module song_select_ctrl
  import song_select_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 2_000_000,
  parameter int NUM_SONGS  = 3
) (
  input logic               clk,
  input logic               reset,
  song_select_ctrl_if.slave bus
);

  localparam logic [3:0] N_SONGS = 4'(NUM_SONGS);

  logic up_p, dn_p, ok_p, bk_p;
  logic up_l, dn_l, ok_l, bk_l;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .raw(bus.btn_up), .level(up_l), .press(up_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .reset(reset), .raw(bus.btn_down), .level(dn_l), .press(dn_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk(clk), .reset(reset), .raw(bus.btn_confirm), .level(ok_l), .press(ok_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bk (
    .clk(clk), .reset(reset), .raw(bus.btn_back), .level(bk_l), .press(bk_p));

  state_t     state_q, state_d;
  logic [3:0] cur_q, cur_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (ok_p && !bk_p) state_d = ST_BROWSE;
      end
      ST_BROWSE: begin
        // bk outranks ok, and either one suppresses a selection change.
        if (bk_p)                state_d = ST_IDLE;
        else if (ok_p)           state_d = ST_PLAY;
        else if (up_p && !dn_p)  cur_d   = wrap_next(cur_q, N_SONGS);
        else if (dn_p && !up_p)  cur_d   = wrap_prev(cur_q, N_SONGS);
      end
      ST_PLAY: begin
        if (bk_p || bus.song_done) state_d = ST_BROWSE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they move on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cur_q           <= 4'd1;
      bus.num         <= 4'd0;
      bus.mode        <= MODE_IDLE;
      bus.song_start  <= 1'b0;
      bus.play_active <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_q           <= cur_d;
      bus.num         <= (state_d == ST_IDLE) ? 4'd0 : cur_d;
      bus.mode        <= mode_of(state_d);
      bus.song_start  <= (state_d == ST_PLAY) && (state_q != ST_PLAY);
      bus.play_active <= (state_d == ST_PLAY);
    end
  end

  assign bus.state     = state_q;
  assign bus.btn_level = {bk_l, ok_l, dn_l, up_l};

endmodule

// File: tb/tb_song_select_ctrl.sv
// Directed bench for song_select_ctrl with a per-cycle behavioural model
// (sample-window debounce rule plus menu rules) and literal spot checks.
module tb_song_select_ctrl;
  import song_select_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int NS  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  song_select_ctrl_if bus();

  song_select_ctrl #(.DEB_CYCLES(DEB), .NUM_SONGS(NS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Button index: 0 up, 1 down, 2 confirm, 3 back.
  // A button's accepted level flips at edge k when the raw samples taken at
  // edges k-2 .. k-1-DEB all differ from the accepted level.
  logic [DEB:0] hist [4];
  logic [3:0]   acc;
  logic [3:0]   prs;
  logic [3:0]   new_prs;
  logic [3:0]   ev;
  logic [3:0]   raw_now;
  logic         all_flip;
  int           m_menu;   // 0 idle, 1 browse, 2 play
  int           m_sel;
  int           m_prev_menu;
  bit           model_valid = 1'b0;
  int           exp_num, exp_mode, exp_start, exp_active;

  always @(posedge clk) begin
    raw_now = {bus.btn_back, bus.btn_confirm, bus.btn_down, bus.btn_up};
    if (!reset) begin
      for (int b = 0; b < 4; b++) hist[b] = '0;
      acc    = '0;
      prs    = '0;
      m_menu = 0;
      m_sel  = 1;
      exp_num    <= 0;
      exp_mode   <= 0;
      exp_start  <= 0;
      exp_active <= 0;
      model_valid <= 1'b1;
    end else begin
      ev = prs;
      for (int b = 0; b < 4; b++) begin
        all_flip = 1'b1;
        for (int i = 1; i <= DEB; i++)
          if (hist[b][i] == acc[b]) all_flip = 1'b0;
        new_prs[b] = all_flip && !acc[b];
        if (all_flip) acc[b] = ~acc[b];
        hist[b] = {hist[b][DEB-1:0], raw_now[b]};
      end
      prs = new_prs;

      m_prev_menu = m_menu;
      if (m_menu == 0) begin
        if (ev[2] && !ev[3]) m_menu = 1;
      end else if (m_menu == 1) begin
        if (ev[3])                m_menu = 0;
        else if (ev[2])           m_menu = 2;
        else if (ev[0] && !ev[1]) m_sel = (m_sel == NS) ? 1 : m_sel + 1;
        else if (ev[1] && !ev[0]) m_sel = (m_sel == 1) ? NS : m_sel - 1;
      end else begin
        if (ev[3] || bus.song_done) m_menu = 1;
      end

      exp_num    <= (m_menu == 0) ? 0 : m_sel;
      exp_mode   <= (m_menu == 0) ? 0 : ((m_menu == 1) ? 2 : 1);
      exp_start  <= (m_menu == 2 && m_prev_menu != 2) ? 1 : 0;
      exp_active <= (m_menu == 2) ? 1 : 0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int         start_cnt = 0;
  int         mode_changes = 0;
  logic [2:0] last_mode = 3'b000;

  always @(negedge clk) begin
    if (model_valid) begin
      chk("num",         int'(bus.num),         exp_num);
      chk("mode",        int'(bus.mode),        exp_mode);
      chk("song_start",  int'(bus.song_start),  exp_start);
      chk("play_active", int'(bus.play_active), exp_active);
      if (bus.song_start) start_cnt++;
      if (bus.mode != last_mode) mode_changes++;
      last_mode = bus.mode;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_btns(input logic [3:0] m);
    bus.btn_up      = m[0];
    bus.btn_down    = m[1];
    bus.btn_confirm = m[2];
    bus.btn_back    = m[3];
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    set_btns(m);
    repeat (hold) @(negedge clk);
    set_btns(4'b0000);
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int s0, mc0;

  initial begin
    set_btns(4'b1111);
    bus.song_done = 1'b0;
    reset = 1'b0;

    // 1: reset with all buttons held high
    repeat (3) @(negedge clk);
    chk("rst_num",    int'(bus.num), 0);
    chk("rst_mode",   int'(bus.mode), 0);
    chk("rst_active", int'(bus.play_active), 0);
    reset = 1'b1;
    set_btns(4'b0000);
    repeat (10) @(negedge clk);
    chk("rst_no_start", start_cnt, 0);
    chk("rst_idle_mode", int'(bus.mode), 0);

    // 2: bouncing confirm gives a single transition into BROWSE
    mc0 = mode_changes;
    bus.btn_confirm = 1'b1; @(negedge clk);
    bus.btn_confirm = 1'b0; @(negedge clk);
    bus.btn_confirm = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_confirm = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    chk("ok_mode", int'(bus.mode), 2);
    chk("ok_num",  int'(bus.num), 1);
    chk("ok_one_transition", mode_changes - mc0, 1);

    // 3: wrap in both directions
    press(4'b0010, 8);
    chk("dn_wrap_num", int'(bus.num), 3);
    press(4'b0001, 8);
    chk("up_wrap_num", int'(bus.num), 1);
    press(4'b0001, 8);
    chk("up_num", int'(bus.num), 2);

    // 4: up+down together ignored, then enter PLAY
    press(4'b0011, 8);
    chk("updn_num", int'(bus.num), 2);
    s0 = start_cnt;
    press(4'b0100, 8);
    chk("play_mode",   int'(bus.mode), 1);
    chk("play_active", int'(bus.play_active), 1);
    chk("play_start_once", start_cnt - s0, 1);

    // 5: selection frozen in PLAY, song_done returns to BROWSE
    press(4'b0001, 8);
    chk("play_up_num", int'(bus.num), 2);
    bus.song_done = 1'b1; @(negedge clk);
    bus.song_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_mode",   int'(bus.mode), 2);
    chk("done_num",    int'(bus.num), 2);
    chk("done_active", int'(bus.play_active), 0);

    // back and confirm together: back wins, selection kept for re-entry
    press(4'b1100, 8);
    chk("bk_ok_mode", int'(bus.mode), 0);
    chk("bk_ok_num",  int'(bus.num), 0);
    press(4'b0100, 8);
    chk("reenter_num", int'(bus.num), 2);

    // 6: reset in PLAY aborts without a start pulse
    press(4'b0100, 8);
    chk("play2_mode", int'(bus.mode), 1);
    s0 = start_cnt;
    reset = 1'b0; @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_num",    int'(bus.num), 0);
    chk("midrst_mode",   int'(bus.mode), 0);
    chk("midrst_active", int'(bus.play_active), 0);
    chk("midrst_no_start", start_cnt - s0, 0);
    press(4'b0100, 8);
    chk("after_rst_mode", int'(bus.mode), 2);
    chk("after_rst_num",  int'(bus.num), 1);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
